// File: rtl/dmem_resp.sv
// Data-memory responder for the M stage: a word array with a fixed access latency.
// Holds MemBusyM while an access is outstanding; ReadDataM is a registered copy of the last load.
module dmem_resp #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        MemBusyM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic [31:0]   rdata;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          we_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] req_idx;
  logic          latch;
  logic          acc;
  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wd;
  logic          busy;

  // Byte-lane bits and bits above the array size are dropped, so addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};
  assign req_idx     = ALUOutM[AW+1:2];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    latch   = 1'b0;
    acc     = 1'b0;
    acc_we  = we_q;
    acc_idx = idx_q;
    acc_wd  = wdata_q;
    busy    = 1'b0;
    case (state)
      IDLE: begin
        busy = MemReqM;
        if (MemReqM && reset) begin
          latch = 1'b1;
          if (LATENCY == 1) begin
            // Single-cycle latency: the access uses the live request on the accepting edge.
            acc     = 1'b1;
            acc_we  = MemWriteM;
            acc_idx = req_idx;
            acc_wd  = WriteDataM;
            state_d = DONE;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy = 1'b1;
        if (cnt == 4'd1) begin
          acc     = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      DONE: begin
        // The request seen here belongs to the completing instruction.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and the load result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (acc && !acc_we) begin
        rdata <= mem[acc_idx];
      end
    end
  end

  // Latched request and array storage; the array survives reset.
  always_ff @(posedge clk) begin
    if (latch) begin
      idx_q   <= req_idx;
      wdata_q <= WriteDataM;
      we_q    <= MemWriteM;
    end
    if (acc && acc_we) begin
      mem[acc_idx] <= acc_wd;
    end
  end

  assign ReadDataM = rdata;
  assign MemBusyM  = busy & reset;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: a LATENCY=2 instance for the main sequences and a
// LATENCY=1 instance for single-cycle and back-to-back behaviour.
module tb_dmem_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req, we;
  logic [31:0] addr, wd, rd;
  logic        busy;

  logic        req1, we1;
  logic [31:0] addr1, wd1, rd1;
  logic        busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(64), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .MemReqM   (req),
    .MemWriteM (we),
    .ALUOutM   (addr),
    .WriteDataM(wd),
    .ReadDataM (rd),
    .MemBusyM  (busy)
  );

  dmem_resp #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
    .clk       (clk),
    .reset     (rst_n),
    .MemReqM   (req1),
    .MemWriteM (we1),
    .ALUOutM   (addr1),
    .WriteDataM(wd1),
    .ReadDataM (rd1),
    .MemBusyM  (busy1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=2 instance; entered and left 1 time unit after a rising edge.
  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] exp, input bit scr, input string tag);
    req = 1'b1; we = w; addr = a; wd = d;
    @(negedge clk); chk({tag, "_busy_c0"}, 32'(busy), 32'd1);
    for (int i = 1; i < LAT; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      if (scr) begin
        addr = 32'h20; wd = 32'h0;
      end
      @(negedge clk); chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    if (!w) chk({tag, "_rdata"}, rd, exp);
    @(posedge clk); #1;
  endtask

  // One access on the LATENCY=1 instance.
  task automatic op1(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input string tag);
    req1 = 1'b1; we1 = w; addr1 = a; wd1 = d;
    @(negedge clk); chk({tag, "_busy_c0"}, 32'(busy1), 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk); chk({tag, "_busy_done"}, 32'(busy1), 32'd0);
    if (!w) chk({tag, "_rdata"}, rd1, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 1'b1; we = 1'b0; addr = 32'h0; wd = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0;

    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rd, 32'h0);
    chk("rst_busy_l1", 32'(busy1), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rdata", rd, 32'h0);
    @(posedge clk); #1;

    op(1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "st_10");
    op(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "ld_10");
    @(negedge clk); chk("hold_rdata", rd, 32'hDEADBEEF);
    @(posedge clk); #1;

    // Write enable without a request must not touch the array.
    we = 1'b1; addr = 32'h10; wd = 32'h0;
    @(negedge clk); chk("noreq_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    we = 1'b0;
    op(1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "noreq_ld");

    op(1'b1, 32'h104, 32'h12345678, 32'h0, 1'b0, "st_104");
    op(1'b0, 32'h004, 32'h0, 32'h12345678, 1'b0, "ld_004");
    op(1'b0, 32'h007, 32'h0, 32'h12345678, 1'b0, "ld_007");

    op(1'b1, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, "st_20");
    op(1'b1, 32'h40, 32'h55AA55AA, 32'h0, 1'b1, "st_40_scr");
    op(1'b0, 32'h40, 32'h0, 32'h55AA55AA, 1'b0, "ld_40");
    op(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, "ld_20");

    op(1'b1, 32'h30, 32'h11111111, 32'h0, 1'b0, "st_30");
    req = 1'b1; we = 1'b1; addr = 32'h30; wd = 32'hA5A5A5A5;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rdata", rd, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_rdata", rd, 32'h0);
    @(posedge clk); #1;
    op(1'b0, 32'h30, 32'h0, 32'h11111111, 1'b0, "ld_30");

    op1(1'b1, 32'h08, 32'h0BADF00D, 32'h0, "l1_st_08");
    op1(1'b1, 32'h0C, 32'h600DCAFE, 32'h0, "l1_st_0c");
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h08;
    @(negedge clk); chk("b2b_busy0", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    addr1 = 32'h0C;
    @(negedge clk);
    chk("b2b_busy1", 32'(busy1), 32'd0);
    chk("b2b_rd_a", rd1, 32'h0BADF00D);
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_busy2", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    chk("b2b_busy3", 32'(busy1), 32'd0);
    chk("b2b_rd_b", rd1, 32'h600DCAFE);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
- Data-memory responder for the memory stage of the pipelined ARM core.
- Accepts the core's M-stage request: address from ALUOutM, store data from WriteDataM, plus a write enable.
- Serves the request from an internal word array with a fixed, parameterised latency, then returns ReadDataM.
- Drives MemBusyM to the hazard unit. The hazard unit uses it to stall F/D/E/M while an access is outstanding.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array; power of two; index width AW = log2(DEPTH_WORDS).
- LATENCY, 2, number of stall cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemReqM  input  1  M-stage instruction is a valid LDR/STR.
- MemWriteM  input  1  1 = store, 0 = load; qualified by MemReqM.
- ALUOutM  input  32  byte address; word index = ALUOutM[AW+1:2].
- WriteDataM  input  32  store data.
- ReadDataM  output  32  load data; valid in DONE.
- MemBusyM  output  1  access outstanding; stall request to hazard unit.

Behaviour:
- State and register reset (reset low, asynchronous): state=IDLE, cnt=0, rdata=0.
- Output reset values: ReadDataM=0 and MemBusyM=0. MemBusyM is forced to 0 while reset is low, independent of MemReqM.
- Array contents are not reset; they are retained across reset.
- States: IDLE, WAIT, DONE. cnt is 4 bits.
- IDLE:
  - MemBusyM = MemReqM (combinational).
  - If MemReqM=1 at the edge: latch idx_q=ALUOutM[AW+1:2], wdata_q=WriteDataM, we_q=MemWriteM.
  - If LATENCY=1: go to DONE and perform the access on that same edge.
  - Otherwise: cnt<=LATENCY-1 and go to WAIT.
- WAIT:
  - MemBusyM=1. Inputs are ignored; the latched copies are used.
  - If cnt==1: perform the access and go to DONE. Otherwise cnt<=cnt-1.
- Performing the access:
  - Store: mem[idx_q]<=wdata_q; rdata is unchanged.
  - Load: rdata<=mem[idx_q].
- DONE:
  - MemBusyM=0, so the pipeline advances on this edge.
  - The MemReqM seen this cycle belongs to the completing instruction and is ignored.
  - Unconditionally go to IDLE.
- ReadDataM = rdata at all times (registered output). It holds the last load value through IDLE and WAIT.
- Latency: a request first seen in IDLE in cycle 0 gives MemBusyM=1 in cycles 0..LATENCY-1. In cycle LATENCY the FSM is in DONE with MemBusyM=0 and ReadDataM valid.
- Back-to-back accesses: a new request is recognised only in IDLE. Two adjacent memory instructions therefore cost LATENCY+1 cycles each (one IDLE cycle between DONE and the next acceptance).
- Address rules:
  - ALUOutM[1:0] is ignored (no alignment fault).
  - Bits above AW+1 are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Write then read of the same word: the load returns the stored value, because the store commits before DONE.
- Reset mid-operation (WAIT, or IDLE with MemReqM high): the pending access is aborted, no array write occurs, and the FSM returns to IDLE with rdata=0.
- Changing inputs during WAIT or DONE has no effect on the access in flight.
- MemWriteM with MemReqM=0 is ignored.

Test Plan:
- Reset: hold reset low with MemReqM=1 → MemBusyM=0 and ReadDataM=0. Release reset with MemReqM=0 → state IDLE, outputs unchanged.
- Store/load, LATENCY=2:
  - Store 0xDEADBEEF to 0x10 → MemBusyM=1 for exactly 2 cycles, then DONE.
  - Load from 0x10 → MemBusyM=1 for 2 cycles; ReadDataM=0xDEADBEEF in cycle 2 and held afterwards.
- Address wrap, DEPTH_WORDS=64: store 0x12345678 to 0x104, load from 0x004 → 0x12345678. Load from 0x007 → same value (low bits ignored).
- Input change in flight: during WAIT change ALUOutM to 0x20 and WriteDataM to 0x0 → the original address and data are used, and word 0x20 is unchanged.
- Reset mid-operation: assert reset during WAIT of a store of 0xA5A5A5A5 to 0x30. Afterwards a load from 0x30 returns the prior contents and ReadDataM=0 immediately after reset.
- LATENCY=1 and back-to-back: two consecutive loads with MemReqM held high → busy pattern 1,0,1,0 (one DONE per access), each ReadDataM correct in its DONE cycle.
